// File: rtl/read_fifo_gather_pkg.sv
// Shared frame geometry and control state encodings for the FIFO gather/scatter pair.
package read_fifo_gather_pkg;

    localparam int RFG_WIDTH = 32;
    localparam int RFG_WORDS = 96;
    localparam int RFG_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } rfg_state_t;

    function automatic logic rfg_is_busy(input rfg_state_t s);
        return (s == ST_FILL) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/read_fifo_gather_shift.sv
// Frame shift register: each captured word enters at the top, so word 0 ends up in the low bits.
module gather_shift
    import read_fifo_gather_pkg::*;
#(
    parameter int WIDTH = RFG_WIDTH,
    parameter int WORDS = RFG_WORDS
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     shift_en_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH*WORDS-1:0]   frame_next_o
);

    localparam int FW = WIDTH * WORDS;

    logic [FW-1:0] frame_q;

    // Value the register takes on a shift; the top loads it as the finished frame.
    assign frame_next_o = {din_i, frame_q[FW-1:WIDTH]};

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else if (shift_en_i) begin
            frame_q <= frame_next_o;
        end
    end

endmodule

// File: rtl/read_fifo_gather.sv
// Gathers WORDS consecutive reads from a normal-mode FIFO into one wide frame with valid/ack handoff.
//   state | meaning
//   IDLE  | counters cleared, waiting for gather_en
//   FILL  | issuing reads and capturing returned words
//   DONE  | frame held on data_out until data_ack
module read_fifo_gather
    import read_fifo_gather_pkg::*;
#(
    parameter int WIDTH = RFG_WIDTH,
    parameter int WORDS = RFG_WORDS
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         fifo_q,
    input  logic                     fifo_empty,
    output logic                     fifo_rdreq,
    input  logic                     gather_en,
    output logic [WIDTH*WORDS-1:0]   data_out,
    output logic                     data_valid,
    input  logic                     data_ack,
    output logic [RFG_CNT_W-1:0]     word_count,
    output logic                     busy
);

    localparam logic [RFG_CNT_W-1:0] LAST    = RFG_CNT_W'(WORDS);
    localparam logic [RFG_CNT_W-1:0] LAST_M1 = RFG_CNT_W'(WORDS - 1);
    localparam logic [RFG_CNT_W-1:0] ONE     = RFG_CNT_W'(1);

    rfg_state_t                 state_q, state_d;
    logic [RFG_CNT_W-1:0]       req_cnt_q, req_cnt_d;
    logic [RFG_CNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic                       data_valid_q, data_valid_d;
    logic                       rd_pend_q;
    logic [WIDTH*WORDS-1:0]     data_out_q;
    logic [WIDTH*WORDS-1:0]     frame_next;
    logic                       rdreq;
    logic                       shift_en;
    logic                       load_frame;

    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        word_cnt_d   = word_cnt_q;
        data_valid_d = data_valid_q;
        rdreq        = 1'b0;
        shift_en     = 1'b0;
        load_frame   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_cnt_d    = '0;
                word_cnt_d   = '0;
                data_valid_d = 1'b0;
                if (gather_en) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                rdreq = !fifo_empty && (req_cnt_q < LAST);
                if (rdreq) begin
                    req_cnt_d = req_cnt_q + ONE;
                end
                // Data for a request made last cycle is on fifo_q now.
                if (rd_pend_q && (word_cnt_q < LAST)) begin
                    shift_en   = 1'b1;
                    word_cnt_d = word_cnt_q + ONE;
                    if (word_cnt_q == LAST_M1) begin
                        load_frame   = 1'b1;
                        data_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (data_ack) begin
                    data_valid_d = 1'b0;
                    req_cnt_d    = '0;
                    word_cnt_d   = '0;
                    state_d      = gather_en ? ST_FILL : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_cnt_q    <= '0;
            word_cnt_q   <= '0;
            data_valid_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            word_cnt_q   <= word_cnt_d;
            data_valid_q <= data_valid_d;
            rd_pend_q    <= rdreq;
            if (load_frame) begin
                data_out_q <= frame_next;
            end
        end
    end

    gather_shift #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) u_shift (
        .clk_in       (clk_in),
        .rst          (rst),
        .shift_en_i   (shift_en),
        .din_i        (fifo_q),
        .frame_next_o (frame_next)
    );

    assign fifo_rdreq = rdreq;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign word_count = word_cnt_q;
    assign busy       = rfg_is_busy(state_q);

endmodule

// File: tb/tb_read_fifo_gather.sv
// Scoreboard bench for read_fifo_gather: behavioural FIFO, expected frames queued at stimulus time.
module tb_read_fifo_gather;

    localparam int W  = 32;
    localparam int N  = 96;
    localparam int FW = W * N;

    logic            clk_in = 1'b0;
    logic            rst;
    logic [W-1:0]    fifo_q = '0;
    logic            fifo_empty = 1'b1;
    logic            fifo_rdreq;
    logic            gather_en;
    logic [FW-1:0]   data_out;
    logic            data_valid;
    logic            data_ack;
    logic [6:0]      word_count;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0]  fifo_mem[$];
    logic [FW-1:0] exp_q[$];
    int  pops_total = 0;
    int  gap_at = -1;
    int  gap_cnt = 0;
    int  rdreq_pulses = 0;
    bit  rand_empty = 0;

    always #5 clk_in = ~clk_in;

    read_fifo_gather dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .gather_en  (gather_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .word_count (word_count),
        .busy       (busy)
    );

    // Normal-mode FIFO: data appears on fifo_q the cycle after a read request.
    always @(posedge clk_in) begin
        cyc++;
        if (gap_cnt > 0) gap_cnt--;
        if (fifo_rdreq) begin
            rdreq_pulses++;
            checks++;
            if (fifo_empty || fifo_mem.size() == 0) begin
                errors++;
                $display("FAIL rdreq_while_empty: rdreq=1 with empty=%0b level=%0d", fifo_empty, fifo_mem.size());
            end else begin
                fifo_q <= fifo_mem.pop_front();
                pops_total++;
                if (pops_total == gap_at) gap_cnt = 10;
            end
        end
    end

    always @(negedge clk_in) begin
        fifo_empty = (fifo_mem.size() == 0) || (gap_cnt > 0) ||
                     (rand_empty && ($urandom_range(0, 2) == 0));
    end

    task automatic cmp_frame(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < N; i++) begin
                if (act[i*W +: W] !== exp[i*W +: W]) begin
                    $display("FAIL %s: word %0d got %08h expected %08h", nm, i, act[i*W +: W], exp[i*W +: W]);
                    break;
                end
            end
        end
    endtask

    // Monitor: pops an expected frame on each data_valid rise and holds it for the stability check.
    logic          prev_valid = 1'b0;
    logic [FW-1:0] cur_exp = '0;
    bit            have_exp = 0;
    always @(posedge clk_in) begin
        #1;
        checks++;
        if (word_count > 7'd96) begin
            errors++;
            $display("FAIL word_count_range: got %0d expected <= 96", word_count);
        end
        if (data_valid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                have_exp = 0;
                $display("FAIL unexpected_frame: data_valid=1 expected no frame");
            end else begin
                cur_exp  = exp_q.pop_front();
                have_exp = 1;
            end
        end
        if (data_valid && have_exp) cmp_frame("frame", data_out, cur_exp);
        if (!data_valid) have_exp = 0;
        prev_valid = data_valid;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // mode 0: i+1, mode 1: random, mode 2: 0xA5 pattern
    task automatic push_words(input int mode, input bit expect_it);
        logic [FW-1:0] f;
        logic [W-1:0]  w;
        f = '0;
        for (int i = 0; i < N; i++) begin
            if (mode == 0)      w = W'(i + 1);
            else if (mode == 1) w = $urandom;
            else                w = 32'hA5A5_A5A5;
            f[i*W +: W] = w;
            fifo_mem.push_back(w);
        end
        if (expect_it) exp_q.push_back(f);
    endtask

    task automatic wait_valid(input string nm, input int start, input int budget, output int lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (data_valid) begin
                lat = cyc - start;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no data_valid within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_wc(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (word_count >= 7'(target)) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_wc_timeout: word_count=%0d expected %0d", word_count, target);
    endtask

    task automatic ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, st, p0, lvl;
        rst = 1'b1;
        gather_en = 1'b0;
        data_ack = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_wc", 32'(word_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdreq", 32'(fifo_rdreq), 0);
        chk("rst_dout", 32'(|data_out), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Basic frame, latency and request count
        push_words(0, 1);
        gather_en = 1'b1;
        st = cyc;
        p0 = rdreq_pulses;
        wait_valid("basic", st, 300, lat);
        chk("basic_latency", 32'(lat), 98);
        chk("basic_pulses", 32'(rdreq_pulses - p0), 96);
        chk("basic_wc", 32'(word_count), 96);
        chk("basic_busy", 32'(busy), 1);

        // Stall in DONE with data waiting in the FIFO
        push_words(1, 1);
        lvl = fifo_mem.size();
        p0 = rdreq_pulses;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("hold_valid", 32'(data_valid), 1);
        end
        chk("hold_pulses", 32'(rdreq_pulses - p0), 0);
        chk("hold_level", 32'(fifo_mem.size()), 32'(lvl));
        ack();
        st = cyc;
        chk("ack_valid", 32'(data_valid), 0);
        chk("ack_wc", 32'(word_count), 0);
        chk("ack_busy_fill", 32'(busy), 1);

        // gather_en dropped mid-frame
        wait_wc(50, 200);
        gather_en = 1'b0;
        wait_valid("en_drop", st, 300, lat);
        chk("en_drop_latency", 32'(lat), 97);
        ack();
        chk("en_drop_busy", 32'(busy), 0);
        tick();
        chk("en_drop_idle_busy", 32'(busy), 0);
        chk("en_drop_idle_wc", 32'(word_count), 0);

        // Empty gap of 10 cycles after word 40
        gap_at = pops_total + 40;
        push_words(1, 1);
        gather_en = 1'b1;
        st = cyc;
        p0 = rdreq_pulses;
        tick();
        gather_en = 1'b0;
        wait_valid("gap", st, 300, lat);
        chk("gap_latency", 32'(lat), 108);
        chk("gap_pulses", 32'(rdreq_pulses - p0), 96);
        gap_at = -1;
        ack();
        chk("gap_busy", 32'(busy), 0);

        // Ack in IDLE is ignored
        ack();
        chk("idle_ack_busy", 32'(busy), 0);
        chk("idle_ack_valid", 32'(data_valid), 0);

        // Reset mid-frame discards the partial frame
        push_words(1, 0);
        gather_en = 1'b1;
        wait_wc(30, 200);
        chk("pre_rst_wc", 32'(word_count), 30);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rdreq", 32'(fifo_rdreq), 0);
        chk("mid_rst_wc", 32'(word_count), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(data_valid), 0);
        chk("mid_rst_dout", 32'(|data_out), 0);
        fifo_mem.delete();
        gather_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        push_words(0, 1);
        gather_en = 1'b1;
        st = cyc;
        wait_valid("post_rst", st, 300, lat);
        chk("post_rst_latency", 32'(lat), 98);

        // A5 pattern, with an ack pulse during FILL that must be ignored
        push_words(2, 1);
        ack();
        st = cyc;
        wait_wc(10, 200);
        ack();
        wait_valid("a5", st, 300, lat);
        chk("a5_latency", 32'(lat), 97);

        // Randomised frames with random empty toggling
        rand_empty = 1;
        for (int f = 0; f < 3; f++) begin
            push_words(1, 1);
            repeat ($urandom_range(0, 5)) tick();
            ack();
            st = cyc;
            wait_valid("rand", st, 2000, lat);
        end
        gather_en = 1'b0;
        ack();
        rand_empty = 0;
        tick();
        chk("end_busy", 32'(busy), 0);
        chk("end_exp_left", 32'(exp_q.size()), 0);
        chk("end_fifo_left", 32'(fifo_mem.size()), 0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_fifo_gather.md
READ_FIFO_GATHER -- requirements
Module: read_fifo_gather

Interface
REQ-001 Parameter WIDTH, default 32, FIFO word width in bits.
REQ-002 Parameter WORDS, default 96, words per frame; frame width WIDTH*WORDS = 3072.
REQ-003 clk_in  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_q  input  32  read data from the upstream FIFO, valid the cycle after fifo_rdreq (normal, non-show-ahead mode).
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_rdreq  output  1  read request to the upstream FIFO.
REQ-008 gather_en  input  1  enables frame collection.
REQ-009 data_out  output  3072  assembled frame; word 0 in bits [31:0], word i in bits [32i+31:32i].
REQ-010 data_valid  output  1  data_out holds a complete frame.
REQ-011 data_ack  input  1  consumer accepts the frame.
REQ-012 word_count  output  7  words captured in the current frame, 0..96.
REQ-013 busy  output  1  high in FILL or DONE.

Function
REQ-014 The block SHALL implement states IDLE, FILL and DONE.
REQ-015 IDLE: counters cleared, fifo_rdreq=0; gather_en=1 -> FILL on the next edge, otherwise stay.
REQ-016 FILL: fifo_rdreq SHALL equal (!fifo_empty && req_cnt<96), combinationally; req_cnt SHALL increment on each cycle fifo_rdreq=1.
REQ-017 A registered rd_pend flag SHALL equal the previous cycle's fifo_rdreq; when rd_pend=1, fifo_q SHALL be shifted into the frame register from the top, {fifo_q, buf[3071:32]}, and word_count SHALL increment.
REQ-018 On the edge that captures the 96th word: data_out SHALL load the completed frame, data_valid SHALL become 1, and the state SHALL become DONE.
REQ-019 Latency: with fifo_empty=0 throughout, fifo_rdreq SHALL be high for FILL cycles 1..96 and data_valid SHALL be high from cycle 98.
REQ-020 fifo_rdreq SHALL never assert while fifo_empty=1, in IDLE, in DONE, or once req_cnt=96.
REQ-021 If fifo_empty rises mid-frame, collection SHALL pause without losing or duplicating words, then resume when it falls.
REQ-022 DONE: data_out and data_valid SHALL stay stable until data_ack=1.
REQ-023 On data_ack=1 in DONE: data_valid->0, req_cnt and word_count->0, and the next state SHALL be FILL if gather_en=1, else IDLE.
REQ-024 data_ack outside DONE SHALL be ignored.
REQ-025 gather_en deasserted during FILL SHALL NOT abort the frame; it is sampled only in IDLE and at the ack in DONE.
REQ-026 Counters are 7 bits; req_cnt and word_count SHALL saturate at 96 and never wrap.

Reset
REQ-027 rst=1 SHALL force state IDLE, fifo_rdreq=0, rd_pend=0, data_out=0, data_valid=0, word_count=0, req_cnt=0, busy=0, frame register=0, regardless of clock.
REQ-028 Reset during a frame SHALL discard the partial frame; words already popped are not recovered.
REQ-029 After rst falls, the first action SHALL be the IDLE evaluation on the next edge.

Structure
REQ-030 WIDTH, WORDS and the state encodings (IDLE=2'b00, FILL=2'b01, DONE=2'b10) SHALL live in a shared package used with the frame-to-FIFO writer.
REQ-031 The frame shift register with capture enable SHALL be one sub-module, gather_shift; the control FSM and counters stay in read_fifo_gather.

Verification
REQ-032 FIFO preloaded with 96 words of value i+1, gather_en=1 -> exactly 96 fifo_rdreq pulses, data_valid at cycle 98, data_out[32i+31:32i]=i+1 for all i.
REQ-033 fifo_empty held high for 10 cycles after word 40 -> no fifo_rdreq during the gap, same data_out, data_valid 10 cycles later (cycle 108).
REQ-034 data_ack held low 20 cycles after data_valid, FIFO non-empty -> data_out and data_valid stable, fifo_rdreq=0, FIFO level unchanged.
REQ-035 gather_en dropped at word 50 -> frame completes at 96 words; after data_ack, state is IDLE and busy=0.
REQ-036 rst pulsed at word_count=30 -> all outputs 0 immediately; a new frame from 96 fresh words is assembled correctly.
REQ-037 Loopback with the frame writer, 3072-bit pattern 0xA5 repeated -> data_out equals the written frame bit-for-bit.
